// File: rtl/ps2_ctrl_decoder.sv
// ps2_ctrl_decoder
//   PS/2 keyboard receiver (scan-code set 2) that turns make/break codes of
//   the direction and fire keys into held-level steering controls.
//
//   Ports
//     clk        in   system clock
//     reset      in   asynchronous active-low reset (0 = reset)
//     ps2_clk    in   raw PS/2 clock pin (asynchronous)
//     ps2_data   in   raw PS/2 data pin (asynchronous)
//     ctrl_up    out  Up-arrow (E0 75) or W (1D) held
//     ctrl_down  out  Down-arrow (E0 72) or S (1B) held
//     ctrl_left  out  Left-arrow (E0 6B) or A (1C) held
//     ctrl_right out  Right-arrow (E0 74) or D (23) held
//     ctrl_fire  out  Z (1A) held
//     scan_valid out  one-cycle pulse, good byte received
//     scan_code  out  last good byte, stable until the next scan_valid
//     frame_err  out  one-cycle pulse on parity/stop error or timeout abort
//     dbg_state  out  frame FSM state (IDLE=0, DATA=1, PARITY=2, STOP=3)
//
//   Handshake: scan_valid is a single-cycle qualifier with no back-pressure;
//   scan_code and ctrl_* already carry the decoded result in that cycle.
module ps2_ctrl_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ctrl_up,
  output logic       ctrl_down,
  output logic       ctrl_left,
  output logic       ctrl_right,
  output logic       ctrl_fire,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err,
  output logic [1:0] dbg_state
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TOW-1:0] TO_MAX   = TOW'(TIMEOUT - 1);

  // Key latch indices
  localparam int K_UP_ARR  = 0;
  localparam int K_W       = 1;
  localparam int K_DN_ARR  = 2;
  localparam int K_S       = 3;
  localparam int K_LF_ARR  = 4;
  localparam int K_A       = 5;
  localparam int K_RT_ARR  = 6;
  localparam int K_D       = 7;
  localparam int K_Z       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // ---------------- input synchronisers ----------------
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // ---------------- clock glitch filter ----------------
  // The counter runs while the synchronised clock disagrees with the filtered
  // level; any agreeing sample restarts it, so only a run of FILTER_LEN
  // consecutive differing samples flips the filtered clock.
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           strobe;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    strobe = 1'b0;
    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FILT_MAX) begin
      filt_d = clk_s2_q;
      fcnt_d = '0;
      strobe = ~clk_s2_q;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // ---------------- frame FSM ----------------
  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           byte_ok, byte_bad, timeout;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    timeout   = 1'b0;
    if (strobe) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          // LSB arrives first, so shift right and insert at the top.
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (dat_s2_q && (^{shift_q, par_q})) byte_ok  = 1'b1;
          else                                 byte_bad = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TO_MAX) begin
        timeout  = 1'b1;
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // ---------------- make/break decode ----------------
  // Decoding is computed from the stop-bit strobe so the key latches load on
  // the same edge that raises scan_valid; ctrl_* thus reflect the byte in the
  // scan_valid cycle itself.
  logic [8:0] keys_q, keys_d;
  logic       ext_q, ext_d, brk_q, brk_d;

  always_comb begin
    keys_d = keys_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    if (timeout || byte_bad) begin
      // Drop any half-received prefix sequence; held keys stay held.
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_ok) begin
      case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        default: begin
          // The ext bit is part of the lookup key, so an arrow never matches
          // without E0 and a letter never matches with it.
          case ({ext_q, shift_q})
            9'h175: keys_d[K_UP_ARR] = ~brk_q;
            9'h01D: keys_d[K_W]      = ~brk_q;
            9'h172: keys_d[K_DN_ARR] = ~brk_q;
            9'h01B: keys_d[K_S]      = ~brk_q;
            9'h16B: keys_d[K_LF_ARR] = ~brk_q;
            9'h01C: keys_d[K_A]      = ~brk_q;
            9'h174: keys_d[K_RT_ARR] = ~brk_q;
            9'h023: keys_d[K_D]      = ~brk_q;
            9'h01A: keys_d[K_Z]      = ~brk_q;
            default: ;
          endcase
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  logic       scan_valid_q, frame_err_q;
  logic [7:0] scan_code_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keys_q       <= 9'd0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= 8'h00;
      frame_err_q  <= 1'b0;
    end else begin
      keys_q       <= keys_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      scan_valid_q <= byte_ok;
      if (byte_ok) scan_code_q <= shift_q;
      frame_err_q  <= byte_bad | timeout;
    end
  end

  assign ctrl_up    = keys_q[K_UP_ARR] | keys_q[K_W];
  assign ctrl_down  = keys_q[K_DN_ARR] | keys_q[K_S];
  assign ctrl_left  = keys_q[K_LF_ARR] | keys_q[K_A];
  assign ctrl_right = keys_q[K_RT_ARR] | keys_q[K_D];
  assign ctrl_fire  = keys_q[K_Z];
  assign scan_valid = scan_valid_q;
  assign scan_code  = scan_code_q;
  assign frame_err  = frame_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_ctrl_decoder.sv
// tb_ps2_ctrl_decoder
//   Drives PS/2 frames into ps2_ctrl_decoder. A reference model (set of held
//   keys indexed by {ext, code}) predicts the response of every good byte;
//   predictions go into exp_q and a monitor compares them on scan_valid.
module tb_ps2_ctrl_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 16;   // PS/2 half bit period in clk cycles
  localparam int GAP        = 40;   // idle cycles between frames

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic ctrl_up, ctrl_down, ctrl_left, ctrl_right, ctrl_fire;
  logic scan_valid, frame_err;
  logic [7:0] scan_code;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ps2_ctrl_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ctrl_up(ctrl_up), .ctrl_down(ctrl_down), .ctrl_left(ctrl_left),
    .ctrl_right(ctrl_right), .ctrl_fire(ctrl_fire),
    .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Expected entry: {fire,right,left,down,up, scan_code}
  logic [12:0] exp_q[$];
  int err_pending = 0;
  bit held[logic [8:0]];
  bit m_ext = 0;
  bit m_brk = 0;

  // 0=up 1=down 2=left 3=right 4=fire, -1 = not a steering key
  function automatic int key_dir(input logic [8:0] k);
    case (k)
      9'h175, 9'h01D: return 0;
      9'h172, 9'h01B: return 1;
      9'h16B, 9'h01C: return 2;
      9'h174, 9'h023: return 3;
      9'h01A:         return 4;
      default:        return -1;
    endcase
  endfunction

  function automatic logic [4:0] model_ctrl();
    logic [4:0] c = 5'd0;
    foreach (held[k]) if (held[k]) c[key_dir(k)] = 1'b1;
    return c;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] k;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = {m_ext, b};
      if (key_dir(k) >= 0) held[k] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
    exp_q.push_back({model_ctrl(), b});
  endtask

  task automatic model_frame_error();
    err_pending++;
    m_ext = 0;
    m_brk = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      tick(6);
      ps2_clk = 1'b0;
      tick(FILTER_LEN / 2);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic [10:0] fr;
    logic        p;
    p  = ~^b;
    if (bad_par) p = ~p;
    fr = {1'b1, p, b, 1'b0};
    if (bad_par) model_frame_error();
    else         model_byte(b);
    for (int i = 0; i < 11; i++) drive_bit(fr[i], glitch && (i == 4));
    ps2_data = 1'b1;
    tick(GAP);
  endtask

  task automatic send_bytes(input logic [7:0] a, input logic [7:0] b, input int n);
    if (n >= 1) send_frame(a, 0, 0);
    if (n >= 2) send_frame(b, 0, 0);
  endtask

  task automatic check_val(input string name, input logic [12:0] act, input logic [12:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_ctrl(input string name);
    check_val(name, {8'd0, ctrl_fire, ctrl_right, ctrl_left, ctrl_down, ctrl_up},
              {8'd0, model_ctrl()});
  endtask

  task automatic check_all_zero(input string name);
    check_val(name, {ctrl_fire, ctrl_right, ctrl_left, ctrl_down, ctrl_up, scan_code}, 13'd0);
    check_val({name, "_pulses"}, {11'd0, scan_valid, frame_err}, 13'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [12:0] exp_e;
  always @(negedge clk) begin
    if (reset) begin
      if (scan_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_scan: got code %h expected none", scan_code);
        end else begin
          exp_e = exp_q.pop_front();
          check_val("scan", {ctrl_fire, ctrl_right, ctrl_left, ctrl_down, ctrl_up, scan_code}, exp_e);
        end
      end
      if (frame_err) begin
        checks++;
        if (err_pending == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else begin
          err_pending--;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] rnd_keys[12] = '{9'h175, 9'h01D, 9'h172, 9'h01B, 9'h16B, 9'h01C,
                              9'h174, 9'h023, 9'h01A, 9'h075, 9'h11D, 9'h029};

  initial begin
    logic [8:0] k;
    bit brk;
    int wait_cnt;

    tick(5);
    check_all_zero("reset_state");
    reset = 1'b1;
    tick(10);
    check_all_zero("after_reset");
    check_val("idle_state", {11'd0, dbg_state}, 13'd0);

    // W make / break
    send_frame(8'h1D, 0, 0);
    check_ctrl("w_make");
    send_bytes(8'hF0, 8'h1D, 2);
    check_ctrl("w_break");

    // Right arrow make / break
    send_bytes(8'hE0, 8'h74, 2);
    check_ctrl("right_make");
    send_frame(8'hE0, 0, 0);
    send_bytes(8'hF0, 8'h74, 2);
    check_ctrl("right_break");

    // Arrow code without prefix, then a bad-parity S
    send_frame(8'h75, 0, 0);
    send_frame(8'h1B, 1, 0);
    check_ctrl("bad_parity_s");

    // Aliases on left, then opposite keys together
    send_frame(8'h1C, 0, 0);
    send_bytes(8'hE0, 8'h6B, 2);
    send_bytes(8'hF0, 8'h1C, 2);
    check_ctrl("left_alias_held");
    send_frame(8'hE0, 0, 0);
    send_bytes(8'hF0, 8'h6B, 2);
    check_ctrl("left_released");
    send_bytes(8'h1D, 8'h1B, 2);
    check_ctrl("up_down_both");
    send_frame(8'h1D, 0, 0);
    check_ctrl("typematic");

    // Partial frame then timeout
    for (int i = 0; i < 5; i++) drive_bit(i == 0 ? 1'b0 : 1'b1, 0);
    ps2_data = 1'b1;
    model_frame_error();
    tick(TIMEOUT + 200);
    check_val("timeout_err", 13'(err_pending), 13'd0);
    send_frame(8'h1A, 0, 0);
    check_ctrl("fire_after_timeout");

    // Glitch on ps2_clk mid-frame
    send_frame(8'h23, 0, 1);
    check_ctrl("glitch_d_make");

    // Reset mid-frame while fire is held
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 0);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_frame");
    held.delete();
    m_ext = 0;
    m_brk = 0;
    ps2_data = 1'b1;
    ps2_clk = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(GAP);
    send_frame(8'h1A, 0, 0);
    check_ctrl("fire_after_reset");

    // Randomised make/break traffic with occasional corrupted frames
    for (int n = 0; n < 30; n++) begin
      k   = rnd_keys[$urandom_range(0, 11)];
      brk = $urandom_range(0, 1);
      if (k[8]) send_frame(8'hE0, 0, 0);
      if (brk) send_frame(8'hF0, $urandom_range(0, 9) == 0, 0);
      send_frame(k[7:0], 0, $urandom_range(0, 7) == 0);
      check_ctrl("random_ctrl");
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 2000) begin
      tick(1);
      wait_cnt++;
    end
    check_val("exp_q_drained", 13'(exp_q.size()), 13'd0);
    check_val("errs_drained", 13'(err_pending), 13'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
